// File: rtl/cfg_pkg.sv
// Shared frame-protocol constants and types for the host config path.
// Used by the frame parser and the UART-side helpers.
package cfg_pkg;

  localparam logic [7:0] HDR_BYTE  = 8'hA5;
  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_START = 8'h02;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_CMDLEN  = 2'd1,
    ERR_CHK     = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_LEN,
    S_PAY,
    S_CHK
  } state_e;

  // A START frame carries no payload; WRITE may carry up to max_len bytes.
  function automatic logic cmd_len_ok(input logic [7:0] cmd,
                                      input logic [7:0] len,
                                      input int unsigned max_len);
    return (32'(len) <= max_len) &&
           ((cmd == CMD_WRITE) || ((cmd == CMD_START) && (len == 8'd0)));
  endfunction

endpackage

// File: rtl/cfg_frame_parser_if.sv
// Byte-in / RAM-write-out bundle of the frame parser.
// master = host/receiver side, slave = parser side.
interface cfg_frame_parser_if #(
  parameter int unsigned ADDR_W = 8
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              wr;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              cfg_commit;
  logic              pc_start;
  logic              frame_err;
  logic [1:0]        err_code;
  logic              busy;

  modport master (
    output rx_data, rx_valid,
    input  wr, wr_addr, wr_data, cfg_commit, pc_start, frame_err, err_code, busy
  );

  modport slave (
    input  rx_data, rx_valid,
    output wr, wr_addr, wr_data, cfg_commit, pc_start, frame_err, err_code, busy
  );
endinterface

// File: rtl/cfg_timeout_cnt.sv
// Idle-cycle counter with clear/load/count and a terminal flag.
// done_c is high on the cycle whose count would reach LIMIT.
module cfg_timeout_cnt #(
  parameter  int unsigned LIMIT = 50000,
  localparam int unsigned W     = $clog2(LIMIT + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done_c
);

  logic [W-1:0] cnt;

  assign done_c = en && (cnt == W'(LIMIT - 1));

  // Holds at the terminal value until cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && !done_c) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/cfg_frame_parser.sv
// Host frame parser: HDR CMD LEN PAYLOAD[LEN] CHK, streams WRITE payloads to
// the config RAM and raises commit/start/error strobes one clock after CHK.
module cfg_frame_parser
  import cfg_pkg::*;
#(
  parameter int unsigned MAX_LEN     = 200,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input logic               clk,
  input logic               rst_n,
  cfg_frame_parser_if.slave bus
);

  localparam int unsigned IDX_W = ADDR_W + 1;

  state_e            state;
  logic [7:0]        cmd;
  logic [7:0]        len;
  logic [7:0]        chk;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_inc_c;

  logic              wr;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              cfg_commit;
  logic              pc_start;
  logic              frame_err;
  err_code_e         err_code;
  logic              busy;
  logic              tmo_c;

  assign idx_inc_c = idx + IDX_W'(1);

  cfg_timeout_cnt #(
    .LIMIT (TIMEOUT_CYC)
  ) u_tmo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (bus.rx_valid || (state == S_IDLE)),
    .load     (1'b0),
    .load_val ('0),
    .en       (state != S_IDLE),
    .done_c   (tmo_c)
  );

  // Frame FSM; a byte arriving on the timeout cycle takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cmd        <= '0;
      len        <= '0;
      chk        <= '0;
      idx        <= '0;
      wr         <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      cfg_commit <= 1'b0;
      pc_start   <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= ERR_NONE;
      busy       <= 1'b0;
    end else begin
      wr         <= 1'b0;
      cfg_commit <= 1'b0;
      pc_start   <= 1'b0;
      frame_err  <= 1'b0;
      if (bus.rx_valid) begin
        case (state)
          S_IDLE: begin
            if (bus.rx_data == HDR_BYTE) begin
              state <= S_CMD;
              busy  <= 1'b1;
            end
          end
          S_CMD: begin
            cmd   <= bus.rx_data;
            chk   <= bus.rx_data;
            state <= S_LEN;
          end
          S_LEN: begin
            len <= bus.rx_data;
            chk <= chk ^ bus.rx_data;
            idx <= '0;
            if (!cmd_len_ok(cmd, bus.rx_data, MAX_LEN)) begin
              frame_err <= 1'b1;
              err_code  <= ERR_CMDLEN;
              state     <= S_IDLE;
              busy      <= 1'b0;
            end else if (bus.rx_data == 8'd0) begin
              state <= S_CHK;
            end else begin
              state <= S_PAY;
            end
          end
          S_PAY: begin
            wr      <= 1'b1;
            wr_addr <= idx[ADDR_W-1:0];
            wr_data <= bus.rx_data;
            chk     <= chk ^ bus.rx_data;
            idx     <= idx_inc_c;
            if (idx_inc_c == IDX_W'(len)) begin
              state <= S_CHK;
            end
          end
          S_CHK: begin
            state <= S_IDLE;
            busy  <= 1'b0;
            if (bus.rx_data == chk) begin
              if (cmd == CMD_START) begin
                pc_start <= 1'b1;
              end else begin
                cfg_commit <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              err_code  <= ERR_CHK;
            end
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end else if (tmo_c) begin
        frame_err <= 1'b1;
        err_code  <= ERR_TIMEOUT;
        state     <= S_IDLE;
        busy      <= 1'b0;
      end
    end
  end

  assign bus.wr         = wr;
  assign bus.wr_addr    = wr_addr;
  assign bus.wr_data    = wr_data;
  assign bus.cfg_commit = cfg_commit;
  assign bus.pc_start   = pc_start;
  assign bus.frame_err  = frame_err;
  assign bus.err_code   = err_code;
  assign bus.busy       = busy;

endmodule
